// File: rtl/self_write_frame_decoder.sv
// SelfWrite receive decoder: edge-detects the word strobe, locks onto the sync
// word, then turns header/payload words into per-row frame write pulses.
module self_write_frame_decoder #(
  parameter int unsigned ROWS        = 16,
  parameter logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1,
  parameter logic [31:0] DESYNC_WORD = 32'hFAB0_FAB0
) (
  input  logic        CLK,
  input  logic        resetn,
  input  logic        SelfWriteStrobe,
  input  logic [31:0] SelfWriteData,
  output logic        frame_valid,
  output logic [31:0] frame_data,
  output logic [3:0]  frame_row,
  output logic        synced,
  output logic        hdr_error,
  output logic [15:0] drop_count,
  output logic [15:0] frames_done
);

  typedef enum logic [1:0] {
    ST_UNSYNC = 2'd0,
    ST_HDR    = 2'd1,
    ST_DATA   = 2'd2
  } state_e;

  localparam logic [4:0] ROWS_LIMIT = 5'(ROWS);

  state_e      state_q, state_d;
  logic        strobe_q;
  logic [3:0]  row_q, row_d;
  logic [15:0] remaining_q, remaining_d;
  logic        frame_valid_q, frame_valid_d;
  logic [31:0] frame_data_q, frame_data_d;
  logic [3:0]  frame_row_q, frame_row_d;
  logic        synced_q, synced_d;
  logic        hdr_error_q, hdr_error_d;
  logic [15:0] drop_count_q, drop_count_d;
  logic [15:0] frames_done_q, frames_done_d;

  logic        acc_s;
  logic        is_sync_s;
  logic        is_desync_s;
  logic [3:0]  hdr_row_s;
  logic [15:0] hdr_len_s;
  logic        hdr_row_bad_s;

  // A word is taken only on the rising edge of the strobe, so a long strobe is one word.
  assign acc_s         = SelfWriteStrobe & ~strobe_q;
  assign is_sync_s     = (SelfWriteData == SYNC_WORD);
  assign is_desync_s   = (SelfWriteData == DESYNC_WORD);
  assign hdr_row_s     = SelfWriteData[31:28];
  assign hdr_len_s     = SelfWriteData[15:0];
  assign hdr_row_bad_s = ({1'b0, hdr_row_s} >= ROWS_LIMIT);

  // Next-state and output decode for the UNSYNC/HDR/DATA word parser.
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    remaining_d   = remaining_q;
    frame_valid_d = 1'b0;
    frame_data_d  = frame_data_q;
    frame_row_d   = frame_row_q;
    hdr_error_d   = hdr_error_q;
    drop_count_d  = drop_count_q;
    frames_done_d = frames_done_q;

    case (state_q)
      ST_UNSYNC: begin
        if (acc_s) begin
          if (is_sync_s) begin
            state_d = ST_HDR;
          end else if (drop_count_q != 16'hFFFF) begin
            drop_count_d = drop_count_q + 16'd1;
          end else begin
            drop_count_d = drop_count_q;
          end
        end else begin
          state_d = ST_UNSYNC;
        end
      end

      ST_HDR: begin
        if (acc_s) begin
          if (is_desync_s) begin
            state_d = ST_UNSYNC;
          end else if (is_sync_s) begin
            state_d = ST_HDR;
          end else if (hdr_row_bad_s) begin
            hdr_error_d = 1'b1;
          end else if (hdr_len_s == 16'd0) begin
            row_d = hdr_row_s;
          end else begin
            row_d       = hdr_row_s;
            remaining_d = hdr_len_s;
            state_d     = ST_DATA;
          end
        end else begin
          state_d = ST_HDR;
        end
      end

      ST_DATA: begin
        // Sync/desync values are plain payload here; only the length ends the burst.
        if (acc_s) begin
          frame_valid_d = 1'b1;
          frame_data_d  = SelfWriteData;
          frame_row_d   = row_q;
          remaining_d   = remaining_q - 16'd1;
          if (remaining_q == 16'd1) begin
            frames_done_d = frames_done_q + 16'd1;
            state_d       = ST_HDR;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end

      default: begin
        state_d = ST_UNSYNC;
      end
    endcase

    synced_d = (state_d != ST_UNSYNC);
  end

  // State and output registers; async reset clears everything including strobe history.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_UNSYNC;
      strobe_q      <= 1'b0;
      row_q         <= 4'd0;
      remaining_q   <= 16'd0;
      frame_valid_q <= 1'b0;
      frame_data_q  <= 32'd0;
      frame_row_q   <= 4'd0;
      synced_q      <= 1'b0;
      hdr_error_q   <= 1'b0;
      drop_count_q  <= 16'd0;
      frames_done_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      strobe_q      <= SelfWriteStrobe;
      row_q         <= row_d;
      remaining_q   <= remaining_d;
      frame_valid_q <= frame_valid_d;
      frame_data_q  <= frame_data_d;
      frame_row_q   <= frame_row_d;
      synced_q      <= synced_d;
      hdr_error_q   <= hdr_error_d;
      drop_count_q  <= drop_count_d;
      frames_done_q <= frames_done_d;
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_data  = frame_data_q;
  assign frame_row   = frame_row_q;
  assign synced      = synced_q;
  assign hdr_error   = hdr_error_q;
  assign drop_count  = drop_count_q;
  assign frames_done = frames_done_q;

endmodule

// File: tb/tb_self_write_frame_decoder.sv
// Directed bench for self_write_frame_decoder (ROWS=8): a vector table of single
// words with expected outputs, plus held-strobe and mid-burst reset sequences.
module tb_self_write_frame_decoder;

  logic        CLK;
  logic        resetn;
  logic        SelfWriteStrobe;
  logic [31:0] SelfWriteData;
  logic        frame_valid;
  logic [31:0] frame_data;
  logic [3:0]  frame_row;
  logic        synced;
  logic        hdr_error;
  logic [15:0] drop_count;
  logic [15:0] frames_done;

  int errors = 0;
  int checks = 0;

  self_write_frame_decoder #(.ROWS(8)) dut (
    .CLK            (CLK),
    .resetn         (resetn),
    .SelfWriteStrobe(SelfWriteStrobe),
    .SelfWriteData  (SelfWriteData),
    .frame_valid    (frame_valid),
    .frame_data     (frame_data),
    .frame_row      (frame_row),
    .synced         (synced),
    .hdr_error      (hdr_error),
    .drop_count     (drop_count),
    .frames_done    (frames_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] word;
    logic        fv;
    logic [31:0] fdata;
    logic [3:0]  frow;
    logic        syn;
    logic        err;
    logic [15:0] drop;
    logic [15:0] done;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_status(input string tag, input logic syn, input logic err,
                            input logic [15:0] drop, input logic [15:0] done);
    chk({tag, ".synced"},      {31'd0, synced},      {31'd0, syn});
    chk({tag, ".hdr_error"},   {31'd0, hdr_error},   {31'd0, err});
    chk({tag, ".drop_count"},  {16'd0, drop_count},  {16'd0, drop});
    chk({tag, ".frames_done"}, {16'd0, frames_done}, {16'd0, done});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".frame_valid"}, {31'd0, frame_valid}, 32'd0);
    chk({tag, ".frame_data"},  frame_data,           32'd0);
    chk({tag, ".frame_row"},   {28'd0, frame_row},   32'd0);
    chk_status(tag, 1'b0, 1'b0, 16'd0, 16'd0);
  endtask

  // Called at a negedge: one-cycle strobe, returns at the next negedge (after the accept edge).
  task automatic put_word(input logic [31:0] w);
    SelfWriteStrobe = 1'b1;
    SelfWriteData   = w;
    @(negedge CLK);
    SelfWriteStrobe = 1'b0;
  endtask

  // Strobe held for n cycles; returns the number of frame_valid pulses seen.
  task automatic hold_word(input logic [31:0] w, input int n, output int pulses);
    pulses = 0;
    SelfWriteStrobe = 1'b1;
    SelfWriteData   = w;
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      if (frame_valid) pulses++;
    end
    SelfWriteStrobe = 1'b0;
    @(negedge CLK);
    if (frame_valid) pulses++;
  endtask

  initial begin
    int pulses;

    vecs[0]  = '{32'h1234_5678, 1'b0, 32'h0,          4'd0, 1'b0, 1'b0, 16'd1, 16'd0};
    vecs[1]  = '{32'hFAB0_FAB1, 1'b0, 32'h0,          4'd0, 1'b1, 1'b0, 16'd1, 16'd0};
    vecs[2]  = '{32'h3000_0002, 1'b0, 32'h0,          4'd0, 1'b1, 1'b0, 16'd1, 16'd0};
    vecs[3]  = '{32'hAAAA_0001, 1'b1, 32'hAAAA_0001,  4'd3, 1'b1, 1'b0, 16'd1, 16'd0};
    vecs[4]  = '{32'hAAAA_0002, 1'b1, 32'hAAAA_0002,  4'd3, 1'b1, 1'b0, 16'd1, 16'd1};
    vecs[5]  = '{32'h3000_0000, 1'b0, 32'h0,          4'd0, 1'b1, 1'b0, 16'd1, 16'd1};
    vecs[6]  = '{32'hFAB0_FAB1, 1'b0, 32'h0,          4'd0, 1'b1, 1'b0, 16'd1, 16'd1};
    vecs[7]  = '{32'hF000_0001, 1'b0, 32'h0,          4'd0, 1'b1, 1'b1, 16'd1, 16'd1};
    vecs[8]  = '{32'h8000_0001, 1'b0, 32'h0,          4'd0, 1'b1, 1'b1, 16'd1, 16'd1};
    vecs[9]  = '{32'h7000_0001, 1'b0, 32'h0,          4'd0, 1'b1, 1'b1, 16'd1, 16'd1};
    vecs[10] = '{32'hFAB0_FAB1, 1'b1, 32'hFAB0_FAB1,  4'd7, 1'b1, 1'b1, 16'd1, 16'd2};
    vecs[11] = '{32'h2001_0002, 1'b0, 32'h0,          4'd0, 1'b1, 1'b1, 16'd1, 16'd2};
    vecs[12] = '{32'hFAB0_FAB0, 1'b1, 32'hFAB0_FAB0,  4'd2, 1'b1, 1'b1, 16'd1, 16'd2};
    vecs[13] = '{32'h5555_5555, 1'b1, 32'h5555_5555,  4'd2, 1'b1, 1'b1, 16'd1, 16'd3};
    vecs[14] = '{32'hFAB0_FAB0, 1'b0, 32'h0,          4'd0, 1'b0, 1'b1, 16'd1, 16'd3};
    vecs[15] = '{32'hFAB0_FAB0, 1'b0, 32'h0,          4'd0, 1'b0, 1'b1, 16'd2, 16'd3};

    resetn          = 1'b0;
    SelfWriteStrobe = 1'b0;
    SelfWriteData   = 32'd0;
    repeat (3) @(negedge CLK);
    chk_all_zero("reset");
    resetn = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 16; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      put_word(vecs[i].word);
      chk({tag, ".frame_valid"}, {31'd0, frame_valid}, {31'd0, vecs[i].fv});
      if (vecs[i].fv) begin
        chk({tag, ".frame_data"}, frame_data, vecs[i].fdata);
        chk({tag, ".frame_row"}, {28'd0, frame_row}, {28'd0, vecs[i].frow});
      end
      chk_status(tag, vecs[i].syn, vecs[i].err, vecs[i].drop, vecs[i].done);
      @(negedge CLK);
      chk({tag, ".gap_valid"}, {31'd0, frame_valid}, 32'd0);
    end

    // Held strobe while unsynced: one dropped word, not five.
    hold_word(32'h0BAD_0000, 5, pulses);
    chk_status("hold_junk", 1'b0, 1'b1, 16'd3, 16'd3);
    hold_word(32'hFAB0_FAB1, 5, pulses);
    chk_status("hold_sync", 1'b1, 1'b1, 16'd3, 16'd3);

    // Held strobe on a payload word: exactly one pulse and the burst stays open.
    put_word(32'h1000_0002);
    @(negedge CLK);
    hold_word(32'h0000_00AA, 4, pulses);
    chk("hold_data.pulses", pulses, 32'd1);
    chk("hold_data.frame_data", frame_data, 32'h0000_00AA);
    chk_status("hold_data", 1'b1, 1'b1, 16'd3, 16'd3);
    put_word(32'h0000_00BB);
    chk("hold_tail.frame_valid", {31'd0, frame_valid}, 32'd1);
    chk("hold_tail.frame_row", {28'd0, frame_row}, 32'd1);
    chk_status("hold_tail", 1'b1, 1'b1, 16'd3, 16'd4);
    @(negedge CLK);

    // Reset after one of four payload words.
    put_word(32'h4000_0004);
    @(negedge CLK);
    put_word(32'hC0DE_0001);
    chk("mid.frame_valid", {31'd0, frame_valid}, 32'd1);
    chk("mid.frame_row", {28'd0, frame_row}, 32'd4);
    @(negedge CLK);
    resetn = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    @(negedge CLK);
    resetn = 1'b1;
    @(negedge CLK);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      put_word(32'hC0DE_0002 + 32'(i));
      if (frame_valid) pulses++;
      @(negedge CLK);
    end
    chk("post_reset.pulses", pulses, 32'd0);
    chk_status("post_reset", 1'b0, 1'b0, 16'd3, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
